// File: rtl/mem_byte_responder_if.sv
// Command, preload and response signals of the byte-serial memory responder.
// The master drives commands and preloads; the slave returns bytes and status.
interface mem_byte_responder_if #(
  parameter int DEPTH_LOG2 = 6
);
  logic                  cmd_valid;
  logic [1:0]            cmd;
  logic [7:0]            addr_in;
  logic [7:0]            data_in;
  logic                  pl_we;
  logic [DEPTH_LOG2-1:0] pl_addr;
  logic [31:0]           pl_data;
  logic                  err_clr;
  logic [7:0]            data_out;
  logic                  data_out_valid;
  logic                  busy;
  logic [DEPTH_LOG2-1:0] pc_out;
  logic                  addr_err;
  logic                  cmd_drop;

  modport master (
    output cmd_valid, cmd, addr_in, data_in, pl_we, pl_addr, pl_data, err_clr,
    input  data_out, data_out_valid, busy, pc_out, addr_err, cmd_drop
  );

  modport slave (
    input  cmd_valid, cmd, addr_in, data_in, pl_we, pl_addr, pl_data, err_clr,
    output data_out, data_out_valid, busy, pc_out, addr_err, cmd_drop
  );
endinterface

// File: rtl/mem_byte_responder.sv
// Byte-serial command responder around a 32-bit word memory: FETCH/STORE/LOAD/JUMP
// with LSB-first byte streams, a word program counter and sticky error flags.
module mem_byte_responder #(
  parameter int DEPTH_LOG2 = 6
) (
  input logic                 clk,
  input logic                 rst,
  mem_byte_responder_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] CMD_FETCH = 2'b00;
  localparam logic [1:0] CMD_STORE = 2'b01;
  localparam logic [1:0] CMD_LOAD  = 2'b10;
  localparam logic [1:0] CMD_JUMP  = 2'b11;

  typedef enum logic [2:0] {IDLE, CAPTURE, TURN, STREAM, COMMIT} state_t;

  state_t                state_q;
  logic [1:0]            cnt_q;
  logic [1:0]            cmd_q;
  logic [31:0]           addr_q;
  logic [31:0]           data_q;
  logic [23:0]           shreg_q;
  logic [7:0]            dout_q;
  logic                  dvld_q;
  logic [DEPTH_LOG2-1:0] pc_q;
  logic                  addr_err_q;
  logic                  cmd_drop_q;

  logic [31:0] mem [DEPTH];

  logic [DEPTH_LOG2-1:0] idx_d;
  logic                  bad_addr_d;
  logic [31:0]           fetch_word_d;
  logic [31:0]           load_word_d;
  logic                  store_we_d;
  logic                  pl_wr_d;
  logic                  err_set_d;
  logic                  drop_set_d;
  logic                  unused_addr_lsbs;

  assign idx_d            = addr_q[DEPTH_LOG2+1:2];
  assign bad_addr_d       = |addr_q[31:8];
  assign unused_addr_lsbs = ^addr_q[1:0];

  // A preload in the accepting cycle targets the word being fetched: forward it.
  assign fetch_word_d = (bus.pl_we && (bus.pl_addr == pc_q)) ? bus.pl_data : mem[pc_q];
  assign load_word_d  = bad_addr_d ? 32'h0 : mem[idx_d];

  assign store_we_d = !rst && (state_q == COMMIT) && (cmd_q == CMD_STORE) && !bad_addr_d;
  assign pl_wr_d    = bus.pl_we && (state_q == IDLE);
  assign err_set_d  = ((state_q == COMMIT) || (state_q == TURN)) && bad_addr_d;
  assign drop_set_d = bus.cmd_valid && (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (store_we_d) begin
      mem[idx_d] <= data_q;
    end else if (pl_wr_d) begin
      mem[bus.pl_addr] <= bus.pl_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 2'd0;
      pc_q       <= '0;
      dout_q     <= 8'h00;
      dvld_q     <= 1'b0;
      addr_err_q <= 1'b0;
      cmd_drop_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            cmd_q  <= bus.cmd;
            addr_q <= {24'h0, bus.addr_in};
            data_q <= {24'h0, bus.data_in};
            cnt_q  <= 2'd1;
            if (bus.cmd == CMD_FETCH) begin
              state_q <= STREAM;
              cnt_q   <= 2'd0;
              dout_q  <= fetch_word_d[7:0];
              shreg_q <= fetch_word_d[31:8];
              dvld_q  <= 1'b1;
            end else begin
              state_q <= CAPTURE;
            end
          end
        end
        CAPTURE: begin
          addr_q[{cnt_q, 3'b000} +: 8] <= bus.addr_in;
          data_q[{cnt_q, 3'b000} +: 8] <= bus.data_in;
          if (cnt_q == 2'd3) begin
            cnt_q   <= 2'd0;
            state_q <= (cmd_q == CMD_LOAD) ? TURN : COMMIT;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        TURN: begin
          state_q <= STREAM;
          cnt_q   <= 2'd0;
          dout_q  <= load_word_d[7:0];
          shreg_q <= load_word_d[31:8];
          dvld_q  <= 1'b1;
        end
        STREAM: begin
          if (cnt_q == 2'd3) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            dout_q  <= 8'h00;
            dvld_q  <= 1'b0;
            if (cmd_q == CMD_FETCH) pc_q <= pc_q + 1'b1;
          end else begin
            cnt_q   <= cnt_q + 2'd1;
            dout_q  <= shreg_q[7:0];
            shreg_q <= {8'h00, shreg_q[23:8]};
          end
        end
        COMMIT: begin
          state_q <= IDLE;
          if ((cmd_q == CMD_JUMP) && !bad_addr_d) pc_q <= idx_d;
        end
        default: state_q <= IDLE;
      endcase

      // Set events take priority over a coincident clear.
      if (err_set_d)         addr_err_q <= 1'b1;
      else if (bus.err_clr)  addr_err_q <= 1'b0;
      if (drop_set_d)        cmd_drop_q <= 1'b1;
      else if (bus.err_clr)  cmd_drop_q <= 1'b0;
    end
  end

  assign bus.data_out       = dout_q;
  assign bus.data_out_valid = dvld_q;
  assign bus.busy           = (state_q != IDLE);
  assign bus.pc_out         = pc_q;
  assign bus.addr_err       = addr_err_q;
  assign bus.cmd_drop       = cmd_drop_q;
endmodule

// File: doc/mem_byte_responder.md
MEM_BYTE_RESPONDER -- requirements
Module: mem_byte_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 6: log2 of the word count of the internal 32-bit memory (64 words).
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-004 SHALL have port cmd_valid  in  1  command strobe; byte 0 of the command is presented in the same cycle.
REQ-005 SHALL have port cmd  in  2  command code: 00 FETCH, 01 STORE, 10 LOAD, 11 JUMP.
REQ-006 SHALL have port addr_in  in  8  address byte stream, LSB first, one byte per cycle.
REQ-007 SHALL have port data_in  in  8  store-data byte stream, LSB first, in parallel with addr_in.
REQ-008 SHALL have port pl_we  in  1  preload write enable.
REQ-009 SHALL have port pl_addr  in  DEPTH_LOG2  preload word index.
REQ-010 SHALL have port pl_data  in  32  preload word.
REQ-011 SHALL have port err_clr  in  1  clears the sticky flags.
REQ-012 SHALL have port data_out  out  8  returned byte, LSB first; 0x00 whenever data_out_valid=0.
REQ-013 SHALL have port data_out_valid  out  1  data_out holds a valid byte.
REQ-014 SHALL have port busy  out  1  high in every state except IDLE.
REQ-015 SHALL have port pc_out  out  DEPTH_LOG2  current fetch word index.
REQ-016 SHALL have port addr_err  out  1  sticky: a STORE/LOAD/JUMP address had nonzero bytes 1-3.
REQ-017 SHALL have port cmd_drop  out  1  sticky: cmd_valid asserted while busy=1.

Function
REQ-018 SHALL implement states IDLE, CAPTURE, TURN, STREAM, COMMIT with a 2-bit byte counter.
REQ-019 SHALL accept a command only when cmd_valid=1 in IDLE; cmd_valid while busy sets cmd_drop and is otherwise ignored.
REQ-020 FETCH accepted at cycle T: STREAM T+1..T+4, data_out = bytes 0..3 of mem[pc] with data_out_valid=1; pc increments at the T+4 edge, wrapping modulo 2^DEPTH_LOG2; IDLE at T+5.
REQ-021 STORE accepted at T: addr/data bytes 0..3 captured at T..T+3 (CAPTURE T+1..T+3), COMMIT at T+4 writes data word to mem[addr[DEPTH_LOG2+1:2]]; IDLE at T+5.
REQ-022 LOAD accepted at T: address captured T..T+3, TURN at T+4 (data_out_valid=0), STREAM T+5..T+8 returns bytes 0..3 of the addressed word; IDLE at T+9.
REQ-023 JUMP accepted at T: address captured T..T+3, data_in ignored; COMMIT at T+4 sets pc <= addr[DEPTH_LOG2+1:2]; IDLE at T+5.
REQ-024 Address bits [1:0] and bits above DEPTH_LOG2+1 of byte 0 SHALL be ignored (word index only).
REQ-025 Nonzero address bytes 1-3: addr_err set at COMMIT/TURN; STORE write suppressed, JUMP leaves pc unchanged, LOAD streams four 0x00 bytes with data_out_valid=1.
REQ-026 pl_we SHALL write mem[pl_addr] only in IDLE; ignored when busy; write visible to reads from the next cycle, including a FETCH/LOAD accepted in the same cycle.
REQ-027 err_clr SHALL clear addr_err and cmd_drop next cycle; a same-cycle set event wins over err_clr.
REQ-028 Back-to-back commands SHALL be accepted on the first IDLE cycle, giving a minimum 5-cycle period for FETCH/STORE/JUMP and 9 for LOAD.

Reset
REQ-029 rst=1 at an edge SHALL force IDLE, counter 0, pc_out 0, data_out 0x00, data_out_valid 0, busy 0, addr_err 0, cmd_drop 0; memory contents are not reset.
REQ-030 rst during any operation SHALL abort it: no partial memory write, no pc update, no further valid bytes.

Verification
REQ-031 Preload mem[0]=0x11223344, mem[1]=0xAABBCCDD; FETCH twice -> bytes 44,33,22,11 then DD,CC,BB,AA; pc_out 0->1->2.
REQ-032 STORE addr 0x00000008 data 0xDEADBEEF, then LOAD addr 0x00000008 -> TURN cycle valid=0, then EF,BE,AD,DE.
REQ-033 JUMP addr 0x000000FC -> pc_out=63; FETCH -> streams mem[63], pc_out wraps to 0.
REQ-034 STORE addr 0x00010004 -> addr_err=1, mem[1] unchanged; LOAD same addr -> four 0x00 bytes; err_clr -> addr_err=0.
REQ-035 cmd_valid held high during a LOAD -> only first accepted, cmd_drop=1; next accept at T+9.
REQ-036 rst asserted at T+2 of a STORE -> IDLE next cycle, target word unchanged on subsequent LOAD.
